// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the FIFO-buffered UART transmitter: data, strobe and FIFO status.
interface uart_tx_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] WR_DATA;
   logic                  WR_EN;
   logic                  FULL;
   logic                  EMPTY;
   logic                  WR_DROP;

   modport master (output WR_DATA, WR_EN, input FULL, EMPTY, WR_DROP);
   modport slave  (input WR_DATA, WR_EN, output FULL, EMPTY, WR_DROP);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with per-frame configurable length, parity, stop bits
// and an internal baud divider; frame settings are captured when a word is popped.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                             clk,
   input  logic                             ARST,
   input  logic [DIV_WIDTH-1:0]             DIV,
   input  logic [$clog2(DATA_WIDTH+1)-1:0]  DATA_LEN,
   input  logic                             PAR_EN,
   input  logic                             PAR_TYP,
   input  logic                             STOP2,
   uart_tx_fifo_if.slave                    wr,
   output logic                             TX_OUT,
   output logic                             BUSY
);
   localparam int LW = $clog2(DATA_WIDTH+1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- FIFO ----------------
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count, count_nx;
   logic                  push, pop;

   // FULL is the registered pre-edge value, so a same-edge pop never rescues a write
   assign push     = wr.WR_EN && !wr.FULL;
   assign count_nx = count + CW'(push) - CW'(pop);

   always_ff @(posedge clk or posedge ARST) begin
      if (ARST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr.FULL    <= 1'b0;
         wr.EMPTY   <= 1'b1;
         wr.WR_DROP <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count      <= count_nx;
         wr.FULL    <= (count_nx == CW'(FIFO_DEPTH));
         wr.EMPTY   <= (count_nx == '0);
         wr.WR_DROP <= wr.WR_EN && wr.FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr.WR_DATA;
   end

   // ---------------- frame engine ----------------
   state_t                state, state_nx;
   logic [DIV_WIDTH-1:0]  cnt, div_last_q, div_last;
   logic [LW-1:0]         len_q, len_eff, bit_cnt;
   logic                  par_en_q, par_typ_q, stop2_q, stop_cnt, par_q;
   logic [DATA_WIDTH-1:0] shreg, shreg_sh;
   logic                  tick, last_data, last_stop, tx_d;

   assign div_last  = (DIV == '0) ? '0 : DIV - DIV_WIDTH'(1);
   assign len_eff   = (DATA_LEN == '0 || DATA_LEN > LW'(DATA_WIDTH)) ? LW'(DATA_WIDTH) : DATA_LEN;
   assign tick      = (cnt == div_last_q);
   assign last_data = (bit_cnt == len_q - LW'(1));
   assign last_stop = (stop_cnt == stop2_q);
   assign shreg_sh  = shreg >> 1;

   always_ff @(posedge clk or posedge ARST) begin
      if (ARST) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         S_IDLE:   if (!wr.EMPTY) begin
                      state_nx = S_START;
                      pop      = 1'b1;
                   end
         S_START:  if (tick) state_nx = S_DATA;
         S_DATA:   if (tick && last_data) state_nx = par_en_q ? S_PARITY : S_STOP;
         S_PARITY: if (tick) state_nx = S_STOP;
         S_STOP:   if (tick && last_stop) begin
                      if (!wr.EMPTY) begin
                         state_nx = S_START;
                         pop      = 1'b1;
                      end else begin
                         state_nx = S_IDLE;
                      end
                   end
         default:  state_nx = S_IDLE;
      endcase
   end

   // Line level for the cycle after this edge; the last data bit has not been folded
   // into par_q yet on the DATA->PARITY edge, so it is added explicitly there.
   always_comb begin
      tx_d = 1'b1;
      BUSY = (state != S_IDLE);
      case (state_nx)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = (state == S_DATA && tick) ? shreg_sh[0] : shreg[0];
         S_PARITY: tx_d = (state == S_DATA) ? (par_q ^ shreg[0] ^ par_typ_q) : (par_q ^ par_typ_q);
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge ARST) begin
      if (ARST) begin
         TX_OUT     <= 1'b1;
         cnt        <= '0;
         div_last_q <= '0;
         len_q      <= LW'(DATA_WIDTH);
         bit_cnt    <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt   <= 1'b0;
         par_q      <= 1'b0;
         shreg      <= '0;
      end else begin
         TX_OUT <= tx_d;
         if (pop) begin
            shreg      <= mem[rd_ptr];
            div_last_q <= div_last;
            len_q      <= len_eff;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            stop2_q    <= STOP2;
            cnt        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_q      <= 1'b0;
         end else if (state != S_IDLE) begin
            cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
            if (tick) begin
               case (state)
                  S_DATA: begin
                     shreg   <= shreg_sh;
                     par_q   <= par_q ^ shreg[0];
                     bit_cnt <= bit_cnt + LW'(1);
                  end
                  S_STOP:  stop_cnt <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench: a timeline model predicts pop edges, drops and line bits.
module tb_uart_tx_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int DIVW  = 16;
   localparam int LW    = $clog2(DW+1);

   logic            clk  = 1'b0;
   logic            ARST = 1'b0;
   logic [DIVW-1:0] DIV  = '0;
   logic [LW-1:0]   DATA_LEN = '0;
   logic            PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
   logic            TX_OUT, BUSY;

   uart_tx_fifo_if #(.DATA_WIDTH(DW)) wr_if ();

   uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
      .clk(clk), .ARST(ARST), .DIV(DIV), .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .STOP2(STOP2), .wr(wr_if), .TX_OUT(TX_OUT), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   typedef struct {
      int          start;
      int          div;
      int          nbits;
      logic [15:0] bits;
   } frame_t;

   frame_t exp_q[$];
   int     pend[$];
   int     free_at = 0;
   bit     wr_at[int];
   bit     drop_at[int];
   bit     mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   function automatic int occ_at(input int k);
      int n = 0;
      foreach (pend[i]) if (pend[i] >= k) n++;
      return n;
   endfunction

   // Frame derived from the line rules: start, LSB-first data, optional parity, stops.
   task automatic model_push(input int k, input logic [7:0] d);
      frame_t f;
      int le, de, s, n;
      bit par;
      le = (DATA_LEN == 0 || int'(DATA_LEN) > DW) ? DW : int'(DATA_LEN);
      de = (DIV == 0) ? 1 : int'(DIV);
      f.bits = '1;
      n = 0;
      par = 1'b0;
      f.bits[n] = 1'b0; n++;
      for (int i = 0; i < le; i++) begin
         f.bits[n] = d[i]; par ^= d[i]; n++;
      end
      if (PAR_EN) begin f.bits[n] = par ^ PAR_TYP; n++; end
      f.bits[n] = 1'b1; n++;
      if (STOP2) begin f.bits[n] = 1'b1; n++; end
      s = (k + 1 > free_at) ? k + 1 : free_at;
      f.start = s;
      f.div   = de;
      f.nbits = n;
      free_at = s + n * de;
      exp_q.push_back(f);
      pend.push_back(s);
   endtask

   task automatic drive(input bit en, input logic [7:0] d, output int k);
      int occ;
      @(negedge clk);
      k   = edge_no;
      occ = occ_at(k);
      chk("FULL", wr_if.FULL, occ == DEPTH);
      chk("EMPTY", wr_if.EMPTY, occ == 0);
      wr_if.WR_EN   = en;
      wr_if.WR_DATA = d;
      if (en) begin
         wr_at[k] = 1'b1;
         if (occ >= DEPTH) drop_at[k] = 1'b1;
         else model_push(k, d);
      end
   endtask

   task automatic set_cfg(input int dv, input int ln, input bit pe, input bit pt, input bit s2);
      DIV = DIVW'(dv); DATA_LEN = LW'(ln); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && edge_no - 1 > free_at) done = 1'b1;
      end
      @(negedge clk);
      chk("idle_reached", done, 1'b1);
      chk("idle_BUSY", BUSY, 1'b0);
      chk("idle_EMPTY", wr_if.EMPTY, 1'b1);
      chk("idle_TX_OUT", TX_OUT, 1'b1);
   endtask

   // Line monitor: a frame begins when the line leaves idle; each clock of it is compared.
   frame_t cur;
   bit     in_frame = 1'b0;
   int     pos, bad_pos;
   bit     bad;
   logic [1:0] bad_act, bad_exp;
   logic   eb;
   always @(negedge clk) begin
      if (ARST || !mon_en) begin
         in_frame = 1'b0;
      end else begin
         if (!in_frame && (TX_OUT !== 1'b1 || BUSY !== 1'b0)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", {30'd0, BUSY, TX_OUT}, 32'h1);
            end else begin
               cur = exp_q.pop_front();
               chk("frame_start_edge", edge_no - 1, cur.start);
               in_frame = 1'b1;
               pos = 0;
               bad = 1'b0;
            end
         end
         if (in_frame) begin
            eb = cur.bits[pos / cur.div];
            if (!bad && (TX_OUT !== eb || BUSY !== 1'b1)) begin
               bad = 1'b1; bad_pos = pos; bad_act = {BUSY, TX_OUT}; bad_exp = {1'b1, eb};
            end
            pos++;
            if (pos == cur.nbits * cur.div) begin
               in_frame = 1'b0;
               checks++;
               if (bad) begin
                  errors++;
                  $display("FAIL frame_bits: frame@%0d clk %0d busy,tx got %b expected %b",
                           cur.start, bad_pos, bad_act, bad_exp);
               end
            end
         end
      end
   end

   int de_chk;
   always @(negedge clk) begin
      if (!ARST && mon_en) begin
         de_chk = edge_no - 1;
         if (wr_at.exists(de_chk)) chk("WR_DROP", wr_if.WR_DROP, drop_at.exists(de_chk));
         else if (wr_if.WR_DROP !== 1'b0) chk("WR_DROP_spurious", wr_if.WR_DROP, 1'b0);
      end
   end

   initial begin
      int k, k0, nd, bad_idle;
      bit ok;
      wr_if.WR_EN = 1'b0;
      wr_if.WR_DATA = '0;
      #2 ARST = 1'b1;
      #1;
      chk("rst_TX_OUT", TX_OUT, 1'b1);
      chk("rst_BUSY", BUSY, 1'b0);
      chk("rst_EMPTY", wr_if.EMPTY, 1'b1);
      chk("rst_FULL", wr_if.FULL, 1'b0);
      chk("rst_WR_DROP", wr_if.WR_DROP, 1'b0);
      repeat (3) @(negedge clk);
      ARST = 1'b0;
      mon_en = 1'b1;

      // T1: 8E1, DIV=4, 0xA5
      set_cfg(4, 8, 1, 0, 0);
      drive(1, 8'hA5, k); drive(0, 0, k);
      wait_idle();

      // T2: ten back-to-back writes into a depth-8 FIFO, one drop expected
      set_cfg(2, 8, 0, 0, 0);
      nd = drop_at.size();
      for (int i = 0; i < 10; i++) drive(1, 8'(8'h10 + i), k);
      drive(0, 0, k);
      chk("T2_drop_count", drop_at.size() - nd, 1);
      wait_idle();

      // T3: 5 data bits, odd parity, two stops, DIV=3
      set_cfg(3, 5, 1, 1, 1);
      drive(1, 8'h1F, k); drive(0, 0, k);
      wait_idle();

      // T4: DIV=0 behaves as DIV=1
      set_cfg(0, 8, 0, 0, 0);
      drive(1, 8'h00, k); drive(0, 0, k);
      wait_idle();

      // T6: two words back to back, no gap between stop and next start
      set_cfg(4, 8, 0, 0, 0);
      drive(1, 8'hC3, k); drive(1, 8'h5A, k); drive(0, 0, k);
      wait_idle();

      // T5: asynchronous reset during data bit 3 of the first word
      set_cfg(8, 8, 0, 0, 0);
      mon_en = 1'b0;
      drive(1, 8'h55, k0); drive(1, 8'h3C, k); drive(0, 0, k);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (edge_no - 1 >= k0 + 1 + 35) ok = 1'b1;
         else @(negedge clk);
      end
      chk("T5_reached", ok, 1'b1);
      chk("T5_pre_TX_OUT", TX_OUT, 1'b0);
      chk("T5_pre_BUSY", BUSY, 1'b1);
      #1 ARST = 1'b1;
      #1;
      chk("T5_rst_TX_OUT", TX_OUT, 1'b1);
      chk("T5_rst_BUSY", BUSY, 1'b0);
      chk("T5_rst_EMPTY", wr_if.EMPTY, 1'b1);
      chk("T5_rst_FULL", wr_if.FULL, 1'b0);
      repeat (2) @(negedge clk);
      ARST = 1'b0;
      exp_q.delete();
      pend.delete();
      free_at = 0;
      bad_idle = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (TX_OUT !== 1'b1 || BUSY !== 1'b0) bad_idle++;
      end
      chk("T5_line_idle_after_reset", bad_idle, 0);
      mon_en = 1'b1;

      // Random traffic; configuration only changes while nothing is queued
      for (int i = 0; i < 600; i++) begin
         if (occ_at(edge_no) == 0 && $urandom_range(0, 7) == 0)
            set_cfg($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom));
         drive($urandom_range(0, 99) < 35, 8'($urandom), k);
      end
      drive(0, 0, k);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
